fusion_issue: RTL
=================

# fusion_issue

Operand sequencer and result assembler for one `quarter_unit` fusion tile: the producer-side counterpart that drives `quarter_unit` operands, sign bits and shift-control codes, then consumes its `out`. The block accepts one multiply request per handshake in 2-, 4- or 8-bit precision. An 8x8 multiply is split into four 4x4 passes, which are issued back-to-back and shift-accumulated into a 16-bit product. It sits between the PE operand buffers and the tile, one instance per quarter_unit.

## Interface
- `QU_LAT`, default 1: cycles from driving `qu_*` to a valid `qu_out`; legal range 1..3.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: high only in IDLE.
- `in_a`, `in_b` input 8: operands; only bits [3:0] are used in modes 0/1.
- `in_mode` input 2: 0 = 2x2 vector, 1 = 4x4, 2 = 8x8, 3 = reserved.
- `in_sign_a`, `in_sign_b` input 1: operand signedness.
- `qu_a`, `qu_b` output 4: nibble operands to the tile.
- `qu_sa`, `qu_sb` output 2: per-2-bit-slice sign flags.
- `qu_sft_ctrl_1`, `qu_sft_ctrl_2` output 1; `qu_sft_ctrl_3` output 2: tile fusion code `{sft_ctrl_3, sft_ctrl_2, sft_ctrl_1}`.
- `qu_out` input 16: tile result.
- `out_valid` output 1, `out_ready` input 1, `out_data` output 16: result handshake.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, HOLD.
  - IDLE: `in_ready` = 1. On `in_valid` the request is latched and the FSM moves to ISSUE with issue count 0.
  - ISSUE: one pass per cycle for N passes (mode 2: N = 4; modes 0, 1, 3: N = 1), then DRAIN.
  - DRAIN: waits for the last capture, then HOLD.
  - HOLD: `out_valid` = 1; on `out_ready` the FSM returns to IDLE.
- Fusion codes:
  - Modes 1 and 2: 4'b1011.
  - Mode 0: 4'b0000.
  - Mode 3: 4'b1111 (the tile outputs 0).
  - Whenever not issuing: code 4'b0000 with zero operands and zero signs.
- Pass order for mode 2 (a-nibble, b-nibble, shift): (lo, lo, 0), (hi, lo, 4), (lo, hi, 4), (hi, hi, 8).
- Sign flags per nibble: a low nibble always drives `sa` = 2'b00. A high nibble, or the single nibble in modes 0/1, drives `sa` = {in_sign_a, 1'b0}; `sb` follows the same rule with `in_sign_b`. In mode 0 the flags are {sign, sign}.
- Accumulator is 16 bits and is cleared at accept. Each captured `qu_out` is shifted left by the pass shift, added mod 2^16, and the result is the final product (an 8x8 signed or unsigned product fits in 16 bits). Modes 0, 1, 3: `out_data` = `qu_out` of the single pass.
- A capture pipeline (valid plus shift tag, QU_LAT deep) tracks in-flight passes; only tagged cycles are accumulated.
- There is no overlap: a new request cannot be accepted until the result handshake completes.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, all `qu_*` 0, state IDLE, so `in_ready` is 1 once `rst_n` is high.
- Request accepted at edge E. Pass k is driven during cycle E+1+k, and its `qu_out` is sampled at edge E+1+k+QU_LAT.
- `out_valid` rises at edge E+N+QU_LAT+1. Mode 2 with QU_LAT = 1: edge E+6.
- `out_data` is stable while `out_valid` is high and `out_ready` is low. Handshake at edge H means `in_ready` is 1 in cycle H+1.
- Reset mid-operation: all state and the capture pipeline clear immediately. Stale tile results arriving after reset are ignored.
- `in_valid` in a non-IDLE state is ignored (not latched).

## Structure
- `bitfusion_pkg` holds:
  - mode enum: MODE_2B, MODE_4B, MODE_8B, MODE_RSV;
  - fusion code constants: SFT_4X4 = 4'b1011, SFT_2X2 = 4'b0000, SFT_2X4_B = 4'b0110, SFT_2X4_A = 4'b0101, SFT_ZERO = 4'b1111;
  - the FSM state enum.
- One sub-module, `fusion_pass_table`: combinational mapping from (mode, pass index, latched operands, signs) to `qu_*` values and shift tag.

## Test plan
- Mode 2, unsigned, a = 200, b = 150, `out_ready` held high -> `out_data` = 0x7530, `out_valid` rises at E+6 and lasts 1 cycle.
- Mode 2, signed, a = 0x80, b = 0x7F -> `out_data` = 0xC080 (-16256). Pass 4 drives `qu_sa` = `qu_sb` = 2'b10.
- Mode 1: signed a = 4'h8, b = 4'h7 -> 0xFFC8; unsigned a = 4'hF, b = 4'hF -> 0x00E1. Code 4'b1011 is driven for 1 cycle.
- Mode 0, unsigned, a = 4'b1011, b = 4'b1101 -> `out_data` = 0x6923. Mode 3 -> 0x0000.
- Backpressure: `out_ready` held low for 5 cycles -> `out_valid` and `out_data` hold, `in_ready` stays 0 and a new `in_valid` is ignored. After the handshake, the next request is accepted 1 cycle later.
- `rst_n` pulsed low during pass 3 -> outputs read 0 immediately. After release, `in_ready` = 1 and a following 8x8 request of 200 x 150 yields 0x7530.

Source files
------------

// File: rtl/bitfusion_pkg.sv
// Shared types and constants for the quarter_unit operand sequencer:
// precision modes, tile fusion codes, sequencer states and the per-pass drive bundle.
package bitfusion_pkg;

  typedef enum logic [1:0] {
    MODE_2B  = 2'd0,
    MODE_4B  = 2'd1,
    MODE_8B  = 2'd2,
    MODE_RSV = 2'd3
  } mode_e;

  // Tile fusion codes, ordered {sft_ctrl_3, sft_ctrl_2, sft_ctrl_1}
  localparam logic [3:0] SFT_4X4   = 4'b1011;
  localparam logic [3:0] SFT_2X2   = 4'b0000;
  localparam logic [3:0] SFT_2X4_B = 4'b0110;
  localparam logic [3:0] SFT_2X4_A = 4'b0101;
  localparam logic [3:0] SFT_ZERO  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [3:0] code;
    logic [3:0] shift;
  } qu_drive_t;

  // Index of the final pass: 8x8 splits into four nibble passes, all else is one
  function automatic logic [1:0] last_pass(mode_e m);
    return (m == MODE_8B) ? 2'd3 : 2'd0;
  endfunction

endpackage

// File: rtl/fusion_pass_table.sv
// Combinational map from (mode, pass index, latched operands, signs) to the
// tile operands, slice sign flags, fusion code and accumulate shift of one pass.
module fusion_pass_table
  import bitfusion_pkg::*;
(
  input  mode_e      mode,
  input  logic [1:0] pass_idx,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sign_a,
  input  logic       sign_b,
  output qu_drive_t  drv
);

  logic a_hi;
  logic b_hi;

  always_comb begin
    drv  = '0;
    // Pass order lo*lo, hi*lo, lo*hi, hi*hi: bit 0 picks the a nibble, bit 1 the b nibble
    a_hi = pass_idx[0];
    b_hi = pass_idx[1];
    case (mode)
      MODE_8B: begin
        drv.a     = a_hi ? a[7:4] : a[3:0];
        drv.b     = b_hi ? b[7:4] : b[3:0];
        drv.sa    = a_hi ? {sign_a, 1'b0} : 2'b00;
        drv.sb    = b_hi ? {sign_b, 1'b0} : 2'b00;
        drv.code  = SFT_4X4;
        drv.shift = {a_hi & b_hi, a_hi ^ b_hi, 2'b00};
      end
      MODE_4B: begin
        drv.a    = a[3:0];
        drv.b    = b[3:0];
        drv.sa   = {sign_a, 1'b0};
        drv.sb   = {sign_b, 1'b0};
        drv.code = SFT_4X4;
      end
      MODE_2B: begin
        drv.a    = a[3:0];
        drv.b    = b[3:0];
        drv.sa   = {sign_a, sign_a};
        drv.sb   = {sign_b, sign_b};
        drv.code = SFT_2X2;
      end
      default: begin
        drv.a    = a[3:0];
        drv.b    = b[3:0];
        drv.code = SFT_ZERO;
      end
    endcase
  end

endmodule

// File: rtl/fusion_issue.sv
// Operand sequencer and result assembler for one quarter_unit tile: issues the
// nibble passes of a request and shift-accumulates the tile results into out_data.
module fusion_issue
  import bitfusion_pkg::*;
#(
  parameter int unsigned QU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [1:0]  in_mode,
  input  logic        in_sign_a,
  input  logic        in_sign_b,
  output logic [3:0]  qu_a,
  output logic [3:0]  qu_b,
  output logic [1:0]  qu_sa,
  output logic [1:0]  qu_sb,
  output logic        qu_sft_ctrl_1,
  output logic        qu_sft_ctrl_2,
  output logic [1:0]  qu_sft_ctrl_3,
  input  logic [15:0] qu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  mode_e      mode_q, mode_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic       sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [15:0] acc_q, acc_d;

  logic [3:0] qu_a_q, qu_a_d, qu_b_q, qu_b_d;
  logic [1:0] qu_sa_q, qu_sa_d, qu_sb_q, qu_sb_d;
  logic [3:0] qu_code_q, qu_code_d;

  // Stage i holds the pass driven i+1 cycles ago; the last stage lines up with qu_out
  logic [QU_LAT-1:0]      cap_vld_q, cap_vld_d;
  logic [QU_LAT-1:0][3:0] cap_sft_q, cap_sft_d;

  logic       issuing;
  logic [15:0] cap_term;
  qu_drive_t  drv;

  fusion_pass_table u_pass_table (
    .mode     (mode_q),
    .pass_idx (cnt_q),
    .a        (a_q),
    .b        (b_q),
    .sign_a   (sign_a_q),
    .sign_b   (sign_b_q),
    .drv      (drv)
  );

  assign issuing = (state_q == ST_ISSUE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    acc_d     = acc_q;
    qu_a_d    = 4'd0;
    qu_b_d    = 4'd0;
    qu_sa_d   = 2'd0;
    qu_sb_d   = 2'd0;
    qu_code_d = 4'd0;
    cap_term  = qu_out << cap_sft_q[QU_LAT-1];

    if (cap_vld_q[QU_LAT-1]) begin
      acc_d = acc_q + cap_term;
    end

    cap_vld_d[0] = issuing;
    cap_sft_d[0] = issuing ? drv.shift : 4'd0;
    for (int i = 1; i < int'(QU_LAT); i++) begin
      cap_vld_d[i] = cap_vld_q[i-1];
      cap_sft_d[i] = cap_sft_q[i-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mode_d   = mode_e'(in_mode);
          a_d      = in_a;
          b_d      = in_b;
          sign_a_d = in_sign_a;
          sign_b_d = in_sign_b;
          acc_d    = 16'd0;
          cnt_d    = 2'd0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        qu_a_d    = drv.a;
        qu_b_d    = drv.b;
        qu_sa_d   = drv.sa;
        qu_sb_d   = drv.sb;
        qu_code_d = drv.code;
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == last_pass(mode_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave only once the last in-flight pass has been accumulated
        if (cap_vld_q == '0) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 2'd0;
      mode_q    <= MODE_2B;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      acc_q     <= 16'd0;
      qu_a_q    <= 4'd0;
      qu_b_q    <= 4'd0;
      qu_sa_q   <= 2'd0;
      qu_sb_q   <= 2'd0;
      qu_code_q <= 4'd0;
      cap_vld_q <= '0;
      cap_sft_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      acc_q     <= acc_d;
      qu_a_q    <= qu_a_d;
      qu_b_q    <= qu_b_d;
      qu_sa_q   <= qu_sa_d;
      qu_sb_q   <= qu_sb_d;
      qu_code_q <= qu_code_d;
      cap_vld_q <= cap_vld_d;
      cap_sft_q <= cap_sft_d;
    end
  end

  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_HOLD);
  assign out_data      = acc_q;
  assign qu_a          = qu_a_q;
  assign qu_b          = qu_b_q;
  assign qu_sa         = qu_sa_q;
  assign qu_sb         = qu_sb_q;
  assign qu_sft_ctrl_3 = qu_code_q[3:2];
  assign qu_sft_ctrl_2 = qu_code_q[1];
  assign qu_sft_ctrl_1 = qu_code_q[0];

endmodule
